// File: rtl/par_traffic_gen.sv
// Parallel-flit traffic source: LFSR-paced injection of whole {hdr,payload,dest}
// flits into a router local port over valid/busy, with packet cap and counters.
module par_traffic_gen #(
    parameter int unsigned ID         = 0,
    parameter int unsigned DESTS      = 9,
    parameter int unsigned HDR_SZ     = 4,
    parameter int unsigned PL_SZ      = 8,
    parameter int unsigned ADDR_SZ    = 4,
    parameter int unsigned PIR        = 255,
    parameter int unsigned MODE       = 0,
    parameter int unsigned FIXED_DEST = 0,
    parameter int unsigned MAX_PKTS   = 0,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              send,
    output logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0]   data,
    output logic                              valid,
    input  logic                              busy,
    output logic                              done,
    output logic [31:0]                       sent_count,
    output logic [31:0]                       stall_count
);

    localparam int unsigned W           = HDR_SZ + PL_SZ + ADDR_SZ;
    localparam logic [15:0] SEED_X      = SEED ^ 16'(ID + 1);
    localparam logic [15:0] SEED_INIT   = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;
    localparam int unsigned MIRROR_DEST = DESTS - 1 - ID;
    localparam int unsigned NEIGH_DEST  = (ID + 1) % DESTS;
    // Centre node in mirror mode would target itself; it stays silent instead.
    localparam bit          MUTE        = (MODE == 2) && (MIRROR_DEST == ID);
    localparam logic [31:0] CNT_MAX     = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [PL_SZ-1:0]   seq_q, seq_d;
    logic [W-1:0]       data_q, data_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [31:0]        sent_q, sent_d;
    logic [31:0]        stall_q, stall_d;

    logic               rate_ok;
    logic               inj;
    logic               last_pkt;
    int unsigned        rnd_dest;
    logic [ADDR_SZ-1:0] dest;
    logic [PL_SZ-1:0]   seq_inc;

    assign data        = data_q;
    assign valid       = valid_q;
    assign done        = done_q;
    assign sent_count  = sent_q;
    assign stall_count = stall_q;

    // LFSR advance (x^16+x^14+x^13+x^11+1, Fibonacci form)
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Injection decision, packet-cap detection and sequence increment
    always_comb begin
        rate_ok  = (PIR >= 255) || (32'(lfsr_q[7:0]) < PIR);
        inj      = send && !done_q && rate_ok && !MUTE;
        last_pkt = (MAX_PKTS != 0) && ((33'(sent_q) + 33'd1) == 33'(MAX_PKTS));
        seq_inc  = seq_q + PL_SZ'(1);
    end

    // Destination selection for the flit being loaded
    always_comb begin
        rnd_dest = 32'(lfsr_q[15:8]) % DESTS;
        if (rnd_dest == ID) begin
            rnd_dest = NEIGH_DEST;
        end
        case (MODE)
            1:       dest = ADDR_SZ'(FIXED_DEST);
            2:       dest = ADDR_SZ'(MIRROR_DEST);
            3:       dest = ADDR_SZ'(NEIGH_DEST);
            default: dest = ADDR_SZ'(rnd_dest);
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (inj) begin
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                if (!busy) begin
                    if (last_pkt) begin
                        state_d = S_DONE;
                    end else if (!inj) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output / datapath next values
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = done_q;
        sent_d  = sent_q;
        stall_d = stall_q;
        seq_d   = seq_q;
        case (state_q)
            S_IDLE: begin
                if (inj) begin
                    data_d  = {HDR_SZ'(ID), seq_q, dest};
                    valid_d = 1'b1;
                end
            end
            S_PEND: begin
                if (busy) begin
                    stall_d = (stall_q == CNT_MAX) ? stall_q : stall_q + 32'd1;
                end else begin
                    sent_d = (sent_q == CNT_MAX) ? sent_q : sent_q + 32'd1;
                    seq_d  = seq_inc;
                    if (last_pkt) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (inj) begin
                        data_d  = {HDR_SZ'(ID), seq_inc, dest};
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
            default: valid_d = 1'b0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q  <= SEED_INIT;
            seq_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            sent_q  <= '0;
            stall_q <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            seq_q   <= seq_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            sent_q  <= sent_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_par_traffic_gen.sv
// Bench for par_traffic_gen: several parameterisations sharing one clock/reset.
// Flit layout with HDR_SZ=4, PL_SZ=8, ADDR_SZ=4: [15:12] hdr, [11:4] payload, [3:0] dest.
module tb_par_traffic_gen;

    localparam int unsigned W = 16;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic send   = 1'b0;
    logic busy_a = 1'b0;
    logic busy_z = 1'b0;

    logic [W-1:0] data_a, data_b, data_c, data_d, data_e, data_f;
    logic valid_a, valid_b, valid_c, valid_d, valid_e, valid_f;
    logic done_a, done_b, done_c, done_d, done_e, done_f;
    logic [31:0] sent_a, sent_b, sent_c, sent_d, sent_e, sent_f;
    logic [31:0] stall_a, stall_b, stall_c, stall_d, stall_e, stall_f;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // a: neighbour mode, node 4 -> dest 5
    par_traffic_gen #(.ID(4), .DESTS(9), .HDR_SZ(4), .PL_SZ(8), .ADDR_SZ(4), .PIR(255), .MODE(3))
    u_a (.clk(clk), .reset(reset), .send(send), .data(data_a), .valid(valid_a), .busy(busy_a),
         .done(done_a), .sent_count(sent_a), .stall_count(stall_a));
    // b: fixed dest 7, capped at 4 packets
    par_traffic_gen #(.ID(1), .DESTS(9), .HDR_SZ(4), .PL_SZ(8), .ADDR_SZ(4), .PIR(255), .MODE(1),
                      .FIXED_DEST(7), .MAX_PKTS(4))
    u_b (.clk(clk), .reset(reset), .send(send), .data(data_b), .valid(valid_b), .busy(busy_z),
         .done(done_b), .sent_count(sent_b), .stall_count(stall_b));
    // c: uniform random, node 2
    par_traffic_gen #(.ID(2), .DESTS(9), .HDR_SZ(4), .PL_SZ(8), .ADDR_SZ(4), .PIR(255), .MODE(0))
    u_c (.clk(clk), .reset(reset), .send(send), .data(data_c), .valid(valid_c), .busy(busy_z),
         .done(done_c), .sent_count(sent_c), .stall_count(stall_c));
    // d: injection rate zero
    par_traffic_gen #(.ID(2), .DESTS(9), .HDR_SZ(4), .PL_SZ(8), .ADDR_SZ(4), .PIR(0), .MODE(0))
    u_d (.clk(clk), .reset(reset), .send(send), .data(data_d), .valid(valid_d), .busy(busy_z),
         .done(done_d), .sent_count(sent_d), .stall_count(stall_d));
    // e: mirror mode, node 0 -> dest 8
    par_traffic_gen #(.ID(0), .DESTS(9), .HDR_SZ(4), .PL_SZ(8), .ADDR_SZ(4), .PIR(255), .MODE(2))
    u_e (.clk(clk), .reset(reset), .send(send), .data(data_e), .valid(valid_e), .busy(busy_z),
         .done(done_e), .sent_count(sent_e), .stall_count(stall_e));
    // f: mirror mode, centre node 4 -> silent
    par_traffic_gen #(.ID(4), .DESTS(9), .HDR_SZ(4), .PL_SZ(8), .ADDR_SZ(4), .PIR(255), .MODE(2))
    u_f (.clk(clk), .reset(reset), .send(send), .data(data_f), .valid(valid_f), .busy(busy_z),
         .done(done_f), .sent_count(sent_f), .stall_count(stall_f));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transfer monitors for the non-table instances
    int         xfer_b = 0;
    int         xfer_c = 0;
    int         xfer_e = 0;
    logic [8:0] seen_c = '0;
    logic       ever_d = 1'b0;
    logic       ever_f = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            xfer_b = 0;
        end else begin
            if (valid_b && !busy_z) begin
                chk("b_payload", 32'(data_b[11:4]), 32'(xfer_b[7:0]));
                chk("b_dest", 32'(data_b[3:0]), 32'd7);
                chk("b_hdr", 32'(data_b[15:12]), 32'd1);
                xfer_b++;
            end
            if (valid_c) begin
                chk("c_dest_not_self", 32'(data_c[3:0] == 4'd2), 32'd0);
                chk("c_dest_in_range", 32'(data_c[3:0] < 4'd9), 32'd1);
                if (data_c[3:0] < 4'd9) seen_c[data_c[3:0]] = 1'b1;
                xfer_c++;
            end
            if (valid_e) begin
                chk("e_dest", 32'(data_e[3:0]), 32'd8);
                xfer_e++;
            end
            if (valid_d) ever_d = 1'b1;
            if (valid_f) ever_f = 1'b1;
        end
    end

    typedef struct {
        logic        send;
        logic        busy;
        logic        exp_valid;
        logic [7:0]  exp_pl;
        logic [31:0] exp_sent;
        logic [31:0] exp_stall;
    } vec_t;

    vec_t        tbl [14];
    logic [W-1:0] held;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'd0, 32'd0, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'd1, 32'd1, 32'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'd2, 32'd2, 32'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'd2, 32'd2, 32'd1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'd2, 32'd2, 32'd2};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'd2, 32'd2, 32'd3};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'd2, 32'd2, 32'd4};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'd2, 32'd2, 32'd5};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'd0, 32'd3, 32'd5};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'd0, 32'd3, 32'd5};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 8'd3, 32'd3, 32'd5};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 8'd3, 32'd3, 32'd6};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'd0, 32'd4, 32'd6};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 8'd4, 32'd4, 32'd6};

        // Reset state
        tick();
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_sent", sent_a, 32'd0);
        chk("rst_stall", stall_a, 32'd0);
        chk("rst_done", 32'(done_b), 32'd0);
        tick();
        reset = 1'b0;

        // Streaming, stalls, idle gaps and send drop while pending
        for (int i = 0; i < 14; i++) begin
            send   = tbl[i].send;
            busy_a = tbl[i].busy;
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(valid_a), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_sent", i), sent_a, tbl[i].exp_sent);
            chk($sformatf("tbl%0d_stall", i), stall_a, tbl[i].exp_stall);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_payload", i), 32'(data_a[11:4]), 32'(tbl[i].exp_pl));
                chk($sformatf("tbl%0d_dest", i), 32'(data_a[3:0]), 32'd5);
                chk($sformatf("tbl%0d_hdr", i), 32'(data_a[15:12]), 32'd4);
            end
        end

        // Long run for random destinations, packet cap and silent sources
        send   = 1'b1;
        busy_a = 1'b0;
        repeat (2100) tick();
        chk("c_all_dests_seen", 32'(seen_c), 32'h1FB);
        chk("c_enough_pkts", 32'(xfer_c >= 2000), 32'd1);
        chk("d_never_valid", 32'(ever_d), 32'd0);
        chk("f_never_valid", 32'(ever_f), 32'd0);
        chk("e_sent_some", 32'(xfer_e > 0), 32'd1);
        chk("b_xfers", 32'(xfer_b), 32'd4);
        chk("b_sent", sent_b, 32'd4);
        chk("b_done", 32'(done_b), 32'd1);
        chk("b_valid_off", 32'(valid_b), 32'd0);

        // Reset while a flit is stalled
        busy_a = 1'b1;
        tick();
        tick();
        chk("pre_rst_valid", 32'(valid_a), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(valid_a), 32'd0);
        chk("async_rst_sent", sent_a, 32'd0);
        chk("async_rst_stall", stall_a, 32'd0);
        chk("async_rst_data", 32'(data_a), 32'd0);
        tick();
        reset = 1'b0;

        // First flit after reset held under busy for five cycles
        tick();
        chk("t2_valid", 32'(valid_a), 32'd1);
        chk("t2_payload0", 32'(data_a[11:4]), 32'd0);
        held = data_a;
        repeat (5) begin
            tick();
            chk("t2_data_stable", 32'(data_a), 32'(held));
            chk("t2_valid_held", 32'(valid_a), 32'd1);
        end
        chk("t2_stall", stall_a, 32'd5);
        chk("t2_sent0", sent_a, 32'd0);
        busy_a = 1'b0;
        tick();
        chk("t2_sent1", sent_a, 32'd1);
        chk("t2_payload1", 32'(data_a[11:4]), 32'd1);
        chk("t2_valid_next", 32'(valid_a), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
